// File: rtl/hpc3_nand_scheduler_if.sv
// Request, randomness, gadget and response bundle of the masked-NAND scheduler.
interface hpc3_nand_scheduler_if #(
    parameter int unsigned security_order = 1
);
    localparam int unsigned NS = security_order + 1;
    localparam int unsigned RW = security_order * NS;

    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*NS-1:0] req_a;
    logic [2*NS-1:0] req_b;
    logic            rnd_valid;
    logic            rnd_ready;
    logic [RW-1:0]   rnd_data;
    logic [NS-1:0]   g_a;
    logic [NS-1:0]   g_b;
    logic [RW-1:0]   g_r;
    logic [NS-1:0]   g_c;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [2*NS-1:0] rsp_c;

    // Environment side: requesters, randomness source, gadget and response sinks.
    modport master (
        output req_valid, req_a, req_b, rnd_valid, rnd_data, g_c, rsp_ready,
        input  req_ready, rnd_ready, g_a, g_b, g_r, rsp_valid, rsp_c
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b, rnd_valid, rnd_data, g_c, rsp_ready,
        output req_ready, rnd_ready, g_a, g_b, g_r, rsp_valid, rsp_c
    );
endinterface

// File: rtl/hpc3_nand_scheduler.sv
// Two-requester scheduler for a shared masked-NAND gadget: round-robin issue
// gated on fresh randomness, a tag pipeline tracking the gadget latency, and a
// one-entry response buffer per requester. Shares are only routed, never combined.
module hpc3_nand_scheduler #(
    parameter int unsigned security_order = 1,
    parameter int unsigned LAT            = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hpc3_nand_scheduler_if.slave bus
);
    localparam int unsigned NS = security_order + 1;
    localparam int unsigned RW = security_order * NS;

    logic [LAT-1:0]  tag_vld_q, tag_vld_d;
    logic [LAT-1:0]  tag_id_q, tag_id_d;
    logic            ptr_q, ptr_d;
    logic [1:0]      rsp_vld_q, rsp_vld_d;
    logic [2*NS-1:0] rsp_c_q, rsp_c_d;

    logic [1:0]      inflight_c;
    logic [1:0]      free_c;
    logic [1:0]      elig_c;
    logic            issue_c;
    logic            gnt_id_c;
    logic            exit_vld_c;
    logic            exit_id_c;

    // Requesters that still have an operation inside the gadget pipeline.
    always_comb begin
        inflight_c = '0;
        for (int s = 0; s < int'(LAT); s++) begin
            if (tag_vld_q[s]) begin
                inflight_c[tag_id_q[s]] = 1'b1;
            end
        end
    end

    // Slot eligibility and round-robin pick; a lone eligible requester ignores the pointer.
    always_comb begin
        free_c   = ~inflight_c & ~rsp_vld_q;
        elig_c   = bus.req_valid & free_c;
        issue_c  = rst_n & bus.rnd_valid & (|elig_c);
        gnt_id_c = (elig_c == 2'b11) ? ptr_q : elig_c[1];
    end

    // Gadget and handshake drive, held at zero outside an issue cycle.
    always_comb begin
        bus.req_ready = '0;
        bus.rnd_ready = 1'b0;
        bus.g_a       = '0;
        bus.g_b       = '0;
        bus.g_r       = '0;
        if (issue_c) begin
            bus.req_ready[gnt_id_c] = 1'b1;
            bus.rnd_ready           = 1'b1;
            bus.g_a = gnt_id_c ? bus.req_a[NS +: NS] : bus.req_a[0 +: NS];
            bus.g_b = gnt_id_c ? bus.req_b[NS +: NS] : bus.req_b[0 +: NS];
            bus.g_r = bus.rnd_data;
        end
    end

    // Next state: tag shift, response capture/release, pointer advance.
    always_comb begin
        tag_vld_d  = (tag_vld_q << 1) | LAT'(issue_c);
        tag_id_d   = (tag_id_q << 1) | LAT'(gnt_id_c);
        exit_vld_c = tag_vld_q[LAT-1];
        exit_id_c  = tag_id_q[LAT-1];
        rsp_vld_d  = rsp_vld_q;
        rsp_c_d    = rsp_c_q;
        for (int i = 0; i < 2; i++) begin
            if (exit_vld_c && (exit_id_c == 1'(i))) begin
                rsp_vld_d[i]           = 1'b1;
                rsp_c_d[i*NS +: NS]    = bus.g_c;
            end else if (rsp_vld_q[i] && bus.rsp_ready[i]) begin
                // Clearing the data keeps result shares off the bus while idle.
                rsp_vld_d[i]           = 1'b0;
                rsp_c_d[i*NS +: NS]    = '0;
            end
        end
        ptr_d = issue_c ? ~gnt_id_c : ptr_q;
    end

    // State registers; reset drops in-flight tags and buffered results silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
            ptr_q     <= 1'b0;
            rsp_vld_q <= '0;
            rsp_c_q   <= '0;
        end else begin
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
            ptr_q     <= ptr_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_c_q   <= rsp_c_d;
        end
    end

    assign bus.rsp_valid = rsp_vld_q;
    assign bus.rsp_c     = rsp_c_q;

endmodule

// File: tb/tb_hpc3_nand_scheduler.sv
// Directed bench for hpc3_nand_scheduler: one LAT=1 instance, one LAT=3 instance.
module tb_hpc3_nand_scheduler;
    logic clk;
    logic rst_n;
    logic rst3_n;

    int n_tests = 0;
    int n_fail  = 0;

    hpc3_nand_scheduler_if #(.security_order(1)) if1 ();
    hpc3_nand_scheduler_if #(.security_order(1)) if3 ();

    hpc3_nand_scheduler #(.security_order(1), .LAT(1)) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if1)
    );

    hpc3_nand_scheduler #(.security_order(1), .LAT(3)) u_dut3 (
        .clk  (clk),
        .rst_n(rst3_n),
        .bus  (if3)
    );

    // Gadget models: result = a ^ b, delayed LAT cycles.
    logic [1:0] gc1_q;
    logic [1:0] g3_s1, g3_s2, g3_s3;
    always @(posedge clk) begin
        gc1_q <= if1.g_a ^ if1.g_b;
        g3_s1 <= if3.g_a ^ if3.g_b;
        g3_s2 <= g3_s1;
        g3_s3 <= g3_s2;
    end
    assign if1.g_c = gc1_q;
    assign if3.g_c = g3_s3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Zero-expected drive checks for an instance that must not issue this cycle.
    task automatic chk_idle1(input string tag);
        chk({tag, "_rdy"}, 32'(if1.req_ready), 32'h0);
        chk({tag, "_rnd"}, 32'(if1.rnd_ready), 32'h0);
        chk({tag, "_ga"},  32'(if1.g_a), 32'h0);
        chk({tag, "_gb"},  32'(if1.g_b), 32'h0);
        chk({tag, "_gr"},  32'(if1.g_r), 32'h0);
    endtask

    logic [1:0] exp_rdy4 [11] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00,
                                  2'b00, 2'b10, 2'b00, 2'b00, 2'b10};
    logic       exp_rv1  [11] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
    logic [1:0] exp_rv5  [6]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};

    initial begin
        int pulses;
        logic       pend_req [2];
        logic [1:0] av [2];
        logic [1:0] bv [2];
        logic       exp_pend [2];
        logic [1:0] exp_c [2];
        int created, n_req_hs, n_rnd_hs, n_rsp_hs;

        rst_n  = 1'b0;
        rst3_n = 1'b0;
        if1.req_valid = '0; if1.req_a = '0; if1.req_b = '0;
        if1.rnd_valid = 1'b0; if1.rnd_data = '0; if1.rsp_ready = '0;
        if3.req_valid = '0; if3.req_a = '0; if3.req_b = '0;
        if3.rnd_valid = 1'b0; if3.rnd_data = '0; if3.rsp_ready = '0;

        // Single op, with stimulus already present during reset.
        if1.req_valid = 2'b01; if1.req_a = 4'b0001; if1.req_b = 4'b0011;
        if1.rnd_valid = 1'b1;  if1.rnd_data = 2'b10;
        @(negedge clk);
        chk("rst_rdy",  32'(if1.req_ready), 32'h0);
        chk("rst_rnd",  32'(if1.rnd_ready), 32'h0);
        chk("rst_ga",   32'(if1.g_a), 32'h0);
        chk("rst_rsp",  32'(if1.rsp_valid), 32'h0);
        chk("rst_rspc", 32'(if1.rsp_c), 32'h0);
        nxt();
        rst_n = 1'b1;
        pulses = 0;
        @(negedge clk);
        pulses += int'(if1.rnd_ready);
        chk("t1_rdy", 32'(if1.req_ready), 32'h1);
        chk("t1_rnd", 32'(if1.rnd_ready), 32'h1);
        chk("t1_ga",  32'(if1.g_a), 32'h1);
        chk("t1_gb",  32'(if1.g_b), 32'h3);
        chk("t1_gr",  32'(if1.g_r), 32'h2);
        nxt();
        if1.req_valid = 2'b00;
        @(negedge clk);
        pulses += int'(if1.rnd_ready);
        chk_idle1("t1_c1");
        chk("t1_c1_rsp", 32'(if1.rsp_valid), 32'h0);
        nxt();
        @(negedge clk);
        pulses += int'(if1.rnd_ready);
        chk("t1_c2_rsp",  32'(if1.rsp_valid), 32'h1);
        chk("t1_c2_rspc", 32'(if1.rsp_c), 32'h2);
        nxt();
        if1.rsp_ready = 2'b01;
        @(negedge clk);
        pulses += int'(if1.rnd_ready);
        chk("t1_c3_rsp",  32'(if1.rsp_valid), 32'h1);
        chk("t1_c3_hold", 32'(if1.rsp_c), 32'h2);
        nxt();
        @(negedge clk);
        pulses += int'(if1.rnd_ready);
        chk("t1_c4_rsp",  32'(if1.rsp_valid), 32'h0);
        chk("t1_c4_rspc", 32'(if1.rsp_c), 32'h0);
        chk("t1_pulses",  32'(pulses), 32'h1);

        // Contention from reset.
        nxt();
        rst_n = 1'b0;
        if1.req_valid = 2'b11; if1.req_a = 4'b1100; if1.req_b = 4'b0101;
        if1.rnd_valid = 1'b1;  if1.rnd_data = 2'b01; if1.rsp_ready = 2'b11;
        nxt();
        nxt();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t2_c0_rdy", 32'(if1.req_ready), 32'h1);
        chk("t2_c0_gb",  32'(if1.g_b), 32'h1);
        nxt();
        @(negedge clk);
        chk("t2_c1_rdy", 32'(if1.req_ready), 32'h2);
        chk("t2_c1_ga",  32'(if1.g_a), 32'h3);
        nxt();
        if1.req_valid = 2'b00;
        @(negedge clk);
        chk("t2_c2_rsp",  32'(if1.rsp_valid), 32'h1);
        chk("t2_c2_rspc", 32'(if1.rsp_c), 32'h1);
        nxt();
        @(negedge clk);
        chk("t2_c3_rsp",  32'(if1.rsp_valid), 32'h2);
        chk("t2_c3_rspc", 32'(if1.rsp_c), 32'h8);
        nxt();
        @(negedge clk);
        chk("t2_c4_rsp", 32'(if1.rsp_valid), 32'h0);

        // Randomness starvation with both requests pending.
        nxt();
        if1.req_valid = 2'b11; if1.req_a = 4'b0110; if1.req_b = 4'b1111;
        if1.rnd_valid = 1'b0;  if1.rnd_data = 2'b11; if1.rsp_ready = 2'b10;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_idle1($sformatf("t3_k%0d", k));
            nxt();
        end

        // Backpressure on requester 0 while requester 1 keeps asking.
        if1.rnd_valid = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            chk($sformatf("t4_rdy_k%0d", k), 32'(if1.req_ready), 32'(exp_rdy4[k]));
            if (k == 0) chk("t4_gr", 32'(if1.g_r), 32'h3);
            chk($sformatf("t4_rv0_k%0d", k), 32'(if1.rsp_valid[0]), 32'(k >= 2));
            chk($sformatf("t4_c0_k%0d", k), 32'(if1.rsp_c[1:0]), (k >= 2) ? 32'h1 : 32'h0);
            chk($sformatf("t4_rv1_k%0d", k), 32'(if1.rsp_valid[1]), 32'(exp_rv1[k]));
            chk($sformatf("t4_c1_k%0d", k), 32'(if1.rsp_c[3:2]), exp_rv1[k] ? 32'h2 : 32'h0);
            nxt();
        end
        if1.req_valid = 2'b00; if1.rsp_ready = 2'b11;
        for (int k = 0; k < 5; k++) nxt();
        @(negedge clk);
        chk("t4_drain", 32'(if1.rsp_valid), 32'h0);
        nxt();

        // Reset one cycle after an issue on the LAT=3 instance.
        rst3_n = 1'b1;
        if3.req_valid = 2'b01; if3.req_a = 4'b0001; if3.req_b = 4'b0010;
        if3.rnd_valid = 1'b1;  if3.rnd_data = 2'b01; if3.rsp_ready = 2'b11;
        @(negedge clk);
        chk("t5_issue", 32'(if3.req_ready), 32'h1);
        nxt();
        if3.req_valid = 2'b00;
        rst3_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("t5_rst_k%0d", k), 32'(if3.rsp_valid), 32'h0);
            chk($sformatf("t5_rst_rnd_k%0d", k), 32'(if3.rnd_ready), 32'h0);
            nxt();
        end
        rst3_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("t5_post_k%0d", k), 32'(if3.rsp_valid), 32'h0);
            nxt();
        end
        if3.req_valid = 2'b11; if3.req_a = 4'b0110; if3.req_b = 4'b0011;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) chk("t5_gnt0", 32'(if3.req_ready), 32'h1);
            if (k == 1) chk("t5_gnt1", 32'(if3.req_ready), 32'h2);
            chk($sformatf("t5_rv_k%0d", k), 32'(if3.rsp_valid), 32'(exp_rv5[k]));
            if (k == 4) chk("t5_c0", 32'(if3.rsp_c), 32'h1);
            if (k == 5) chk("t5_c1", 32'(if3.rsp_c), 32'h4);
            nxt();
            if (k == 1) if3.req_valid = 2'b00;
        end

        // Random traffic: scoreboard plus freshness/zero-drive checks every cycle.
        for (int i = 0; i < 2; i++) begin
            pend_req[i] = 1'b0; av[i] = '0; bv[i] = '0;
            exp_pend[i] = 1'b0; exp_c[i] = '0;
        end
        created = 0; n_req_hs = 0; n_rnd_hs = 0; n_rsp_hs = 0;
        for (int c = 0; c < 4000 && n_rsp_hs < 100; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend_req[i] && created < 100 && $urandom_range(0, 1) == 1) begin
                    pend_req[i] = 1'b1;
                    av[i] = 2'($urandom);
                    bv[i] = 2'($urandom);
                    created++;
                end
            end
            if1.req_valid = {pend_req[1], pend_req[0]};
            if1.req_a     = {av[1], av[0]};
            if1.req_b     = {bv[1], bv[0]};
            if1.rnd_valid = ($urandom_range(0, 3) != 0);
            if1.rnd_data  = 2'($urandom);
            if1.rsp_ready = 2'($urandom);
            @(negedge clk);
            chk("r_rnd_vs_gnt", 32'(if1.rnd_ready), 32'(|if1.req_ready));
            if (if1.rnd_ready) begin
                n_rnd_hs++;
                chk("r_gr", 32'(if1.g_r), 32'(if1.rnd_data));
                chk("r_onehot", 32'($countones(if1.req_ready)), 32'h1);
                chk("r_rdy_valid", 32'(if1.req_ready & if1.req_valid), 32'(if1.req_ready));
            end else begin
                chk("r_ga0", 32'(if1.g_a), 32'h0);
                chk("r_gb0", 32'(if1.g_b), 32'h0);
                chk("r_gr0", 32'(if1.g_r), 32'h0);
            end
            for (int i = 0; i < 2; i++) begin
                if (if1.req_ready[i]) begin
                    chk("r_slot_free", 32'(exp_pend[i]), 32'h0);
                    chk("r_ga", 32'(if1.g_a), 32'(av[i]));
                    chk("r_gb", 32'(if1.g_b), 32'(bv[i]));
                end
                if (if1.rsp_valid[i]) begin
                    chk("r_rsp_exp", 32'(exp_pend[i]), 32'h1);
                    chk("r_rsp_c", 32'(if1.rsp_c[i*2 +: 2]), 32'(exp_c[i]));
                end else begin
                    chk("r_rsp_zero", 32'(if1.rsp_c[i*2 +: 2]), 32'h0);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (if1.rsp_valid[i] && if1.rsp_ready[i]) begin
                    exp_pend[i] = 1'b0;
                    n_rsp_hs++;
                end
                if (if1.req_ready[i]) begin
                    exp_pend[i] = 1'b1;
                    exp_c[i]    = av[i] ^ bv[i];
                    pend_req[i] = 1'b0;
                    n_req_hs++;
                end
            end
            nxt();
        end
        chk("r_req_hs", 32'(n_req_hs), 32'd100);
        chk("r_rnd_hs", 32'(n_rnd_hs), 32'd100);
        chk("r_rsp_hs", 32'(n_rsp_hs), 32'd100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
